// File: rtl/field_set_ctrl_if.sv
// field_set_ctrl_if
//   Write handshake between the front-panel setting controller and the
//   timekeeping datapath register banks.
//   master : the setting controller (drives the request, receives the ack)
//   slave  : the datapath (receives the request, drives the ack)
//   Signals:
//     to_wr_en   write request, held until acked
//     to_wr_tgt  register bank: 00 time, 01 date, 10 alarm
//     to_wr_fld  field code: 01 sec/day, 10 min/month, 11 hour/year
//     to_wr_val  field value
//     fr_wr_ack  datapath accepted the pending write
interface field_set_ctrl_if;
  logic       to_wr_en;
  logic [1:0] to_wr_tgt;
  logic [1:0] to_wr_fld;
  logic [6:0] to_wr_val;
  logic       fr_wr_ack;

  modport master (
    output to_wr_en,
    output to_wr_tgt,
    output to_wr_fld,
    output to_wr_val,
    input  fr_wr_ack
  );

  modport slave (
    input  to_wr_en,
    input  to_wr_tgt,
    input  to_wr_fld,
    input  to_wr_val,
    output fr_wr_ack
  );
endinterface

// File: rtl/field_set_ctrl.sv
// field_set_ctrl
//   Front-panel setting controller. Synchronizes and debounces the two
//   active-low keys, toggles alarm set mode on KEY1, and on each KEY0 press
//   range-checks the switch value and issues one handshaked field write into
//   the time, date or alarm register bank.
//
//   Parameters:
//     DEB_CYCLES  stable synchronized samples needed to accept a key change (1..255)
//     TO_CYCLES   write-ack timeout in cycles (only with SETCTRL_TIMEOUT_EN)
//   Build option:
//     SETCTRL_TIMEOUT_EN  when defined, an unacked write is abandoned after
//                         TO_CYCLES cycles with an error pulse
//   Ports:
//     CK50M          system clock, rising edge
//     RSTn           asynchronous active-low reset
//     fr_SW[9:0]     [9] date select, [8:7] field, [6:0] value
//     fr_KEY[1:0]    raw active-low keys: [0] set, [1] alarm-mode toggle
//     wr             write handshake (master side)
//     to_alarm_mode  alarm set mode active
//     to_err         one-cycle pulse on rejected set or timeout
//     to_busy        a write is in progress
module field_set_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int TO_CYCLES  = 1024
) (
  input  logic                   CK50M,
  input  logic                   RSTn,
  input  logic [9:0]             fr_SW,
  input  logic [1:0]             fr_KEY,
  field_set_ctrl_if.master       wr,
  output logic                   to_alarm_mode,
  output logic                   to_err,
  output logic                   to_busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CHECK = 2'b01,
    ST_WRITE = 2'b10
  } state_t;

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  // Out-of-range parameters leave this block as the only trace; nothing is built in it.
  if ((DEB_CYCLES < 1) || (DEB_CYCLES > 255) || (TO_CYCLES < 1)) begin : g_param_range
  end

  // Range check of one field value for the selected register bank.
  function automatic logic field_ok(input logic [1:0] tgt,
                                    input logic [1:0] fld,
                                    input logic [6:0] val);
    logic ok;
    ok = 1'b0;
    if (tgt == 2'b01) begin
      case (fld)
        2'b01:   ok = (val >= 7'd1) && (val <= 7'd31);
        2'b10:   ok = (val >= 7'd1) && (val <= 7'd12);
        2'b11:   ok = (val <= 7'd99);
        default: ok = 1'b0;
      endcase
    end else begin
      case (fld)
        2'b01:   ok = (val <= 7'd59);
        2'b10:   ok = (val <= 7'd59);
        2'b11:   ok = (val <= 7'd23);
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Key front end
  logic [1:0] sync1_r;
  logic [1:0] sync2_r;
  logic [1:0] level_r;
  logic [1:0] armed_r;
  logic [1:0] press_r;
  logic [7:0] cnt_r [2];

  // FSM and outputs
  state_t     state_r;
  state_t     state_next_s;
  logic       load_s;
  logic       launch_s;
  logic       err_next_s;
  logic [1:0] tgt_sel_s;
  logic [1:0] lat_tgt_r;
  logic [1:0] lat_fld_r;
  logic [6:0] lat_val_r;
  logic       wr_en_r;
  logic [1:0] wr_tgt_r;
  logic [1:0] wr_fld_r;
  logic [6:0] wr_val_r;
  logic       mode_r;
  logic       err_r;
  logic       busy_r;

  // Synchronizers and debouncers for both keys. The synchronizers reset to 0
  // so a key that is really held at reset release never looks released; a key
  // only becomes armed once a genuine released level is seen, which keeps a
  // key held through reset from counting as a press.
  always_ff @(posedge CK50M or negedge RSTn) begin
    if (!RSTn) begin
      sync1_r  <= 2'b00;
      sync2_r  <= 2'b00;
      level_r  <= 2'b11;
      armed_r  <= 2'b00;
      press_r  <= 2'b00;
      cnt_r[0] <= 8'd0;
      cnt_r[1] <= 8'd0;
    end else begin
      sync1_r <= fr_KEY;
      sync2_r <= sync1_r;
      for (int k = 0; k < 2; k++) begin
        press_r[k] <= 1'b0;
        if (sync2_r[k] == level_r[k]) begin
          cnt_r[k] <= 8'd0;
        end else if (cnt_r[k] == DEB_LAST) begin
          level_r[k] <= sync2_r[k];
          cnt_r[k]   <= 8'd0;
          // Level differs from a released (1) level only on a fall.
          press_r[k] <= armed_r[k] & level_r[k];
        end else begin
          cnt_r[k] <= cnt_r[k] + 8'd1;
        end
        if (sync2_r[k] && level_r[k]) begin
          armed_r[k] <= 1'b1;
        end else begin
          armed_r[k] <= armed_r[k];
        end
      end
    end
  end

  // Target bank from the current (pre-toggle) mode and the date select switch.
  always_comb begin
    tgt_sel_s = 2'b00;
    if (mode_r) begin
      tgt_sel_s = 2'b10;
    end else if (fr_SW[9]) begin
      tgt_sel_s = 2'b01;
    end else begin
      tgt_sel_s = 2'b00;
    end
  end

`ifdef SETCTRL_TIMEOUT_EN
  localparam int             TO_W    = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_r;
  logic            timeout_hit_s;

  assign timeout_hit_s = (to_cnt_r == TO_LAST);

  // Cycles spent in WRITE; cleared whenever the FSM is elsewhere.
  always_ff @(posedge CK50M or negedge RSTn) begin
    if (!RSTn) begin
      to_cnt_r <= '0;
    end else if (state_r == ST_WRITE) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end else begin
      to_cnt_r <= '0;
    end
  end
`endif

  // Next-state logic for the set sequence.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    launch_s     = 1'b0;
    err_next_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (press_r[0]) begin
          state_next_s = ST_CHECK;
          load_s       = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (field_ok(lat_tgt_r, lat_fld_r, lat_val_r)) begin
          state_next_s = ST_WRITE;
          launch_s     = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
          err_next_s   = 1'b1;
        end
      end
      ST_WRITE: begin
        // An ack in the expiry cycle takes priority over the timeout.
        if (wr.fr_wr_ack) begin
          state_next_s = ST_IDLE;
        end
`ifdef SETCTRL_TIMEOUT_EN
        else if (timeout_hit_s) begin
          state_next_s = ST_IDLE;
          err_next_s   = 1'b1;
        end
`endif
        else begin
          state_next_s = ST_WRITE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register, latched request and registered outputs. Outputs are
  // computed from the next state so they line up with the WRITE state itself.
  always_ff @(posedge CK50M or negedge RSTn) begin
    if (!RSTn) begin
      state_r   <= ST_IDLE;
      lat_tgt_r <= 2'b00;
      lat_fld_r <= 2'b00;
      lat_val_r <= 7'd0;
      wr_en_r   <= 1'b0;
      wr_tgt_r  <= 2'b00;
      wr_fld_r  <= 2'b00;
      wr_val_r  <= 7'd0;
      mode_r    <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      // Switches are static while the operator presses a key, so they are
      // sampled directly at the press.
      if (load_s) begin
        lat_tgt_r <= tgt_sel_s;
        lat_fld_r <= fr_SW[8:7];
        lat_val_r <= fr_SW[6:0];
      end
      if (launch_s) begin
        wr_tgt_r <= lat_tgt_r;
        wr_fld_r <= lat_fld_r;
        wr_val_r <= lat_val_r;
      end
      wr_en_r <= (state_next_s == ST_WRITE);
      busy_r  <= (state_next_s == ST_WRITE);
      err_r   <= err_next_s;
      mode_r  <= mode_r ^ press_r[1];
    end
  end

  assign wr.to_wr_en   = wr_en_r;
  assign wr.to_wr_tgt  = wr_tgt_r;
  assign wr.to_wr_fld  = wr_fld_r;
  assign wr.to_wr_val  = wr_val_r;
  assign to_alarm_mode = mode_r;
  assign to_err        = err_r;
  assign to_busy       = busy_r;

endmodule

// File: tb/tb_field_set_ctrl.sv
// tb_field_set_ctrl
//   Self-checking bench for field_set_ctrl: a table of set operations with
//   hand-derived expectations, randomized sets checked against a range-table
//   reference model, and hand-written multi-cycle corner sequences.
module tb_field_set_ctrl;

  localparam int DEB = 4;
  localparam int TOC = 16;
  // Key driven low between edges: sync (2) + debounce (DEB) + CHECK + WRITE.
  localparam int WR_CYC = DEB + 4;

  logic       CK50M;
  logic       RSTn;
  logic [9:0] fr_SW;
  logic [1:0] fr_KEY;
  logic       to_alarm_mode;
  logic       to_err;
  logic       to_busy;

  field_set_ctrl_if bus();

  field_set_ctrl #(.DEB_CYCLES(DEB), .TO_CYCLES(TOC)) dut (
    .CK50M        (CK50M),
    .RSTn         (RSTn),
    .fr_SW        (fr_SW),
    .fr_KEY       (fr_KEY),
    .wr           (bus),
    .to_alarm_mode(to_alarm_mode),
    .to_err       (to_err),
    .to_busy      (to_busy)
  );

  initial CK50M = 1'b0;
  always #5 CK50M = ~CK50M;

  int n_total = 0;
  int n_pass  = 0;

  // Monitor counters used by the corner sequences
  int   wr_rises = 0;
  int   wr_high  = 0;
  int   err_cnt  = 0;
  logic prev_wr  = 1'b0;

  // Model state
  bit model_mode = 1'b0;
  int hi_time [4] = '{0, 59, 59, 23};
  int hi_date [4] = '{0, 31, 12, 99};
  int lo_date [4] = '{0, 1, 1, 0};

  typedef struct {
    bit         tog;
    logic [9:0] sw;
    bit         ok;
    logic [1:0] tgt;
    bit         mode;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic bit model_ok(input logic [1:0] tgt, input logic [1:0] fld, input logic [6:0] val);
    int v;
    v = int'(val);
    if (fld == 2'b00) return 1'b0;
    if (tgt == 2'b01) return (v >= lo_date[fld]) && (v <= hi_date[fld]);
    return v <= hi_time[fld];
  endfunction

  function automatic logic [1:0] model_tgt(input bit mode, input logic [9:0] sw);
    if (mode) return 2'b10;
    if (sw[9]) return 2'b01;
    return 2'b00;
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CK50M); #1;
      if (bus.to_wr_en && !prev_wr) wr_rises++;
      if (bus.to_wr_en) wr_high++;
      if (to_err) err_cnt++;
      prev_wr = bus.to_wr_en;
    end
  endtask

  task automatic clear_mon();
    wr_rises = 0;
    wr_high  = 0;
    err_cnt  = 0;
    prev_wr  = bus.to_wr_en;
  endtask

  // One KEY0 set: 10-cycle press, ack two cycles after the request is seen.
  task automatic run_set(input logic [9:0] sw, input bit exp_ok, input logic [1:0] exp_tgt, input string nm);
    int first, wr_cyc, err_cyc, err_first, busy_first;
    logic [1:0] c_tgt, c_fld;
    logic [6:0] c_val;
    first = 0; wr_cyc = 0; err_cyc = 0; err_first = 0; busy_first = 0;
    c_tgt = 2'b00; c_fld = 2'b00; c_val = 7'd0;
    fr_SW = sw;
    fr_KEY[0] = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      @(posedge CK50M); #1;
      if (bus.to_wr_en) begin
        if (first == 0) begin
          first = c;
          c_tgt = bus.to_wr_tgt; c_fld = bus.to_wr_fld; c_val = bus.to_wr_val;
          busy_first = int'(to_busy);
        end
        wr_cyc++;
      end
      if (to_err) begin
        if (err_cyc == 0) err_first = c;
        err_cyc++;
      end
      if (first != 0 && c == first + 2) bus.fr_wr_ack = 1'b1;
      if (first != 0 && c == first + 3) bus.fr_wr_ack = 1'b0;
      if (c == 10) fr_KEY[0] = 1'b1;
    end
    bus.fr_wr_ack = 1'b0;
    if (exp_ok) begin
      chk({nm, " wr_start"}, first, WR_CYC);
      chk({nm, " tgt"}, int'(c_tgt), int'(exp_tgt));
      chk({nm, " fld"}, int'(c_fld), int'(sw[8:7]));
      chk({nm, " val"}, int'(c_val), int'(sw[6:0]));
      chk({nm, " wr_len"}, wr_cyc, 3);
      chk({nm, " busy"}, busy_first, 1);
      chk({nm, " no_err"}, err_cyc, 0);
    end else begin
      chk({nm, " no_wr"}, wr_cyc, 0);
      chk({nm, " err_len"}, err_cyc, 1);
      chk({nm, " err_at"}, err_first, WR_CYC);
    end
    chk({nm, " busy_end"}, int'(to_busy), 0);
  endtask

  task automatic press_key1();
    fr_KEY[1] = 1'b0;
    tick(10);
    fr_KEY[1] = 1'b1;
    tick(12);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] sw;
    logic [1:0] f;
    bit         ok;

    RSTn = 1'b0;
    fr_SW = 10'd0;
    fr_KEY = 2'b11;
    bus.fr_wr_ack = 1'b0;

    vt[0]  = '{1'b0, {1'b0, 2'b11, 7'd23}, 1'b1, 2'b00, 1'b0};
    vt[1]  = '{1'b0, {1'b1, 2'b01, 7'd31}, 1'b1, 2'b01, 1'b0};
    vt[2]  = '{1'b0, {1'b1, 2'b10, 7'd12}, 1'b1, 2'b01, 1'b0};
    vt[3]  = '{1'b0, {1'b1, 2'b11, 7'd25}, 1'b1, 2'b01, 1'b0};
    vt[4]  = '{1'b0, {1'b1, 2'b10, 7'd13}, 1'b0, 2'b01, 1'b0};
    vt[5]  = '{1'b0, {1'b0, 2'b01, 7'd60}, 1'b0, 2'b00, 1'b0};
    vt[6]  = '{1'b0, {1'b0, 2'b00, 7'd5},  1'b0, 2'b00, 1'b0};
    vt[7]  = '{1'b0, {1'b1, 2'b01, 7'd0},  1'b0, 2'b01, 1'b0};
    vt[8]  = '{1'b0, {1'b0, 2'b10, 7'd59}, 1'b1, 2'b00, 1'b0};
    vt[9]  = '{1'b0, {1'b0, 2'b11, 7'd24}, 1'b0, 2'b00, 1'b0};
    vt[10] = '{1'b1, {1'b1, 2'b11, 7'd0},  1'b1, 2'b10, 1'b1};
    vt[11] = '{1'b0, {1'b0, 2'b10, 7'd0},  1'b1, 2'b10, 1'b1};
    vt[12] = '{1'b0, {1'b1, 2'b01, 7'd5},  1'b1, 2'b10, 1'b1};
    vt[13] = '{1'b0, {1'b0, 2'b11, 7'd24}, 1'b0, 2'b10, 1'b1};
    vt[14] = '{1'b1, {1'b1, 2'b11, 7'd99}, 1'b1, 2'b01, 1'b0};

    #23;
    chk("rst wr_en", int'(bus.to_wr_en), 0);
    chk("rst tgt", int'(bus.to_wr_tgt), 0);
    chk("rst fld", int'(bus.to_wr_fld), 0);
    chk("rst val", int'(bus.to_wr_val), 0);
    chk("rst mode", int'(to_alarm_mode), 0);
    chk("rst err", int'(to_err), 0);
    chk("rst busy", int'(to_busy), 0);
    @(negedge CK50M);
    RSTn = 1'b1;
    tick(8);

    // Table-driven sets
    for (int i = 0; i < 15; i++) begin
      if (vt[i].tog) press_key1();
      chk($sformatf("vec%0d mode", i), int'(to_alarm_mode), int'(vt[i].mode));
      run_set(vt[i].sw, vt[i].ok, vt[i].tgt, $sformatf("vec%0d", i));
    end
    model_mode = to_alarm_mode;

    // Randomized sets against the range-table model
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        press_key1();
        model_mode = ~model_mode;
        chk($sformatf("rnd%0d mode", i), int'(to_alarm_mode), int'(model_mode));
      end
      f = 2'($urandom_range(0, 3));
      sw = {1'($urandom_range(0, 1)), f, 7'($urandom_range(0, ($urandom_range(0, 1) == 1) ? 127 : 32))};
      ok = model_ok(model_tgt(model_mode, sw), sw[8:7], sw[6:0]);
      run_set(sw, ok, model_tgt(model_mode, sw), $sformatf("rnd%0d", i));
    end
    if (model_mode) begin
      press_key1();
      model_mode = 1'b0;
    end

    // Bounce shorter than the debounce window: no press
    clear_mon();
    fr_SW = {1'b0, 2'b01, 7'd3};
    for (int i = 0; i < 5; i++) begin
      fr_KEY[0] = 1'b0; tick(1);
      fr_KEY[0] = 1'b1; tick(1);
    end
    fr_KEY[0] = 1'b0; tick(DEB - 1);
    fr_KEY[0] = 1'b1; tick(20);
    chk("bounce no_wr", wr_rises, 0);
    chk("bounce no_err", err_cnt, 0);

    // Second press while WRITE is pending is dropped
    clear_mon();
    fr_SW = {1'b0, 2'b01, 7'd30};
    fr_KEY[0] = 1'b0; tick(10);
    fr_KEY[0] = 1'b1; tick(10);
    fr_SW = {1'b0, 2'b01, 7'd40};
    fr_KEY[0] = 1'b0; tick(10);
    fr_KEY[0] = 1'b1; tick(12);
    chk("dbl still_wr", int'(bus.to_wr_en), 1);
    chk("dbl val_held", int'(bus.to_wr_val), 30);
    bus.fr_wr_ack = 1'b1; tick(1);
    bus.fr_wr_ack = 1'b0;
    chk("dbl wr_done", int'(bus.to_wr_en), 0);
    tick(20);
    chk("dbl one_write", wr_rises, 1);
    chk("dbl no_err", err_cnt, 0);

    // Simultaneous KEY0 and KEY1: write uses pre-toggle mode
    clear_mon();
    fr_SW = {1'b1, 2'b11, 7'd50};
    fr_KEY = 2'b00;
    tick(WR_CYC);
    chk("both wr_en", int'(bus.to_wr_en), 1);
    chk("both tgt", int'(bus.to_wr_tgt), 1);
    chk("both mode", int'(to_alarm_mode), 1);
    bus.fr_wr_ack = 1'b1; tick(1);
    bus.fr_wr_ack = 1'b0;
    chk("both wr_done", int'(bus.to_wr_en), 0);
    fr_KEY = 2'b11; tick(12);
    press_key1();
    chk("both mode_back", int'(to_alarm_mode), 0);

    // Ack held high: ignored in IDLE, then a one-cycle write
    clear_mon();
    bus.fr_wr_ack = 1'b1;
    tick(5);
    chk("ack_idle no_wr", wr_rises, 0);
    fr_SW = {1'b0, 2'b01, 7'd7};
    fr_KEY[0] = 1'b0;
    tick(WR_CYC);
    chk("minwr wr_en", int'(bus.to_wr_en), 1);
    tick(1);
    chk("minwr wr_fall", int'(bus.to_wr_en), 0);
    fr_KEY[0] = 1'b1;
    bus.fr_wr_ack = 1'b0;
    tick(14);
    chk("minwr len", wr_high, 1);

    // Reset during a write, key held across reset release
    fr_SW = {1'b0, 2'b10, 7'd10};
    fr_KEY[0] = 1'b0;
    tick(WR_CYC);
    chk("rstw wr_before", int'(bus.to_wr_en), 1);
    #2 RSTn = 1'b0;
    #1;
    chk("rstw wr_en", int'(bus.to_wr_en), 0);
    chk("rstw val", int'(bus.to_wr_val), 0);
    chk("rstw fld", int'(bus.to_wr_fld), 0);
    chk("rstw busy", int'(to_busy), 0);
    chk("rstw err", int'(to_err), 0);
    tick(3);
    RSTn = 1'b1;
    clear_mon();
    tick(25);
    chk("rstw held_no_wr", wr_rises, 0);
    fr_KEY[0] = 1'b1;
    tick(20);
    chk("rstw release_no_wr", wr_rises, 0);
    chk("rstw no_err", err_cnt, 0);
    run_set({1'b0, 2'b10, 7'd45}, 1'b1, 2'b00, "after_rst");

`ifdef SETCTRL_TIMEOUT_EN
    // No ack: request held TOC cycles, then an error pulse
    begin
      int wr_cyc, err_cyc, err_at, wr_last, busy_at_err;
      wr_cyc = 0; err_cyc = 0; err_at = 0; wr_last = 0; busy_at_err = 1;
      fr_SW = {1'b0, 2'b01, 7'd1};
      fr_KEY[0] = 1'b0;
      for (int c = 1; c <= WR_CYC + TOC + 6; c++) begin
        @(posedge CK50M); #1;
        if (bus.to_wr_en) begin wr_cyc++; wr_last = c; end
        if (to_err) begin err_cyc++; err_at = c; busy_at_err = int'(to_busy); end
        if (c == 10) fr_KEY[0] = 1'b1;
      end
      chk("to wr_len", wr_cyc, TOC);
      chk("to err_len", err_cyc, 1);
      chk("to err_at", err_at, wr_last + 1);
      chk("to busy", busy_at_err, 0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
